snpu_policy_deck: RTL and testbench

Policy-card deck engine for the SNPU: holds the 17-card policy deck (6 liberal, 11 fascist), the discard pile, the current legislative hand and the enacted board tallies. It sits directly upstream of the `tt_um_SNPU` I/O top level, which decodes pin commands into deck operations and drives the resulting state back out to the pins. Shuffling uses an internal LFSR and a one-swap-per-cycle Fisher-Yates sequencer.

---
 rtl/snpu_policy_deck.sv | 244 ++++++++++++++++++++++++
 tb/tb_snpu_policy_deck.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/snpu_policy_deck.sv
`timescale 1ns/1ps
// snpu_policy_deck: policy deck, discard counts, legislative hand and board tallies, with an LFSR-driven Fisher-Yates shuffle.
// Optional feature macro: SNPU_AUTO_RESHUFFLE_EN (reshuffle automatically when the stack drops below three cards).
module snpu_policy_deck #(
  parameter logic [7:0] LFSR_SEED = 8'hA5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       op_valid,
  input  logic [2:0] op_code,
  input  logic [1:0] op_arg,
  output logic       op_ready,
  output logic       busy,
  output logic       err,
  output logic [2:0] hand,
  output logic [1:0] hand_n,
  output logic [2:0] peek,
  output logic [4:0] stack_n,
  output logic [4:0] disc_n,
  output logic [2:0] board_lib,
  output logic [2:0] board_fas
);

  localparam int unsigned DECK_N = 17;
  localparam int unsigned CNT_W  = 5;
  localparam int unsigned LFSR_W = 8;

  localparam logic [DECK_N-1:0] STACK_INIT = 17'h0_003F;
  localparam logic [CNT_W-1:0]  DECK_CNT   = 5'd17;
  localparam logic [2:0]        LIB_MAX    = 3'd5;
  localparam logic [2:0]        FAS_MAX    = 3'd6;

  localparam logic [2:0] OP_NOP     = 3'd0;
  localparam logic [2:0] OP_RESET   = 3'd1;
  localparam logic [2:0] OP_SHUFFLE = 3'd2;
  localparam logic [2:0] OP_DRAW3   = 3'd3;
  localparam logic [2:0] OP_DISCARD = 3'd4;
  localparam logic [2:0] OP_ENACT   = 3'd5;
  localparam logic [2:0] OP_TOPDECK = 3'd6;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_MERGE = 2'd1,
    S_SWAP  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [DECK_N-1:0]   stack_q, stack_d;
  logic [LFSR_W-1:0]   lfsr_q, lfsr_d;
  logic [CNT_W-1:0]    idx_q, idx_d;
  logic [CNT_W-1:0]    disc_lib_q, disc_lib_d;
  logic [CNT_W-1:0]    stack_n_d, disc_n_d;
  logic [2:0]          hand_d, peek_d, board_lib_d, board_fas_d;
  logic [1:0]          hand_n_d;
  logic                err_d, busy_d;

  logic [CNT_W-1:0]    top_pos, merged_n, swap_j;
  logic [1:0]          hand_lib;
  logic                sel_card, top_card, sel_full, top_full;

  // Mask of the lowest n bits; n never exceeds the deck size here.
  function automatic logic [DECK_N-1:0] low_mask(input logic [CNT_W-1:0] n);
    return DECK_N'((18'd1 << n) - 18'd1);
  endfunction

  // Smallest all-ones value covering i, used to draw a candidate swap index.
  function automatic logic [CNT_W-1:0] span_mask(input logic [CNT_W-1:0] i);
    if (i <= 5'd1)       return 5'd1;
    else if (i <= 5'd3)  return 5'd3;
    else if (i <= 5'd7)  return 5'd7;
    else if (i <= 5'd15) return 5'd15;
    else                 return 5'd31;
  endfunction

  // Fibonacci LFSR for x^8+x^6+x^5+x^4+1.
  function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
    return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
  endfunction

  // Next-state and next-output logic.
  always_comb begin
    state_d     = state_q;
    stack_d     = stack_q;
    lfsr_d      = lfsr_step(lfsr_q);
    idx_d       = idx_q;
    disc_lib_d  = disc_lib_q;
    stack_n_d   = stack_n;
    disc_n_d    = disc_n;
    hand_d      = hand;
    hand_n_d    = hand_n;
    board_lib_d = board_lib;
    board_fas_d = board_fas;
    err_d       = err;

    top_pos  = stack_n - 5'd1;
    merged_n = stack_n + disc_n;
    swap_j   = lfsr_q[4:0] & span_mask(idx_q);
    hand_lib = 2'(hand[0]) + 2'(hand[1]) + 2'(hand[2]);
    sel_card = hand[op_arg];
    top_card = (stack_n != 5'd0) && stack_q[top_pos];
    sel_full = sel_card ? (board_lib == LIB_MAX) : (board_fas == FAS_MAX);
    top_full = top_card ? (board_lib == LIB_MAX) : (board_fas == FAS_MAX);

    case (state_q)
      S_IDLE: begin
        if (op_valid && op_ready) begin
          err_d = 1'b0;
          case (op_code)
            OP_NOP: ;
            OP_RESET: begin
              stack_d     = STACK_INIT;
              stack_n_d   = DECK_CNT;
              hand_d      = 3'b000;
              hand_n_d    = 2'd0;
              disc_n_d    = 5'd0;
              disc_lib_d  = 5'd0;
              board_lib_d = 3'd0;
              board_fas_d = 3'd0;
              idx_d       = 5'd0;
              lfsr_d      = LFSR_SEED;
            end
            OP_SHUFFLE: state_d = S_MERGE;
            OP_DRAW3: begin
              if (hand_n != 2'd0 || stack_n < 5'd3) begin
                err_d = 1'b1;
              end else begin
                hand_d    = {stack_q[top_pos - 5'd2], stack_q[top_pos - 5'd1], stack_q[top_pos]};
                hand_n_d  = 2'd3;
                stack_d   = stack_q & low_mask(stack_n - 5'd3);
                stack_n_d = stack_n - 5'd3;
              end
            end
            OP_DISCARD: begin
              if (op_arg >= hand_n) begin
                err_d = 1'b1;
              end else begin
                disc_n_d   = disc_n + 5'd1;
                disc_lib_d = disc_lib_q + 5'(sel_card);
                hand_n_d   = hand_n - 2'd1;
                case (op_arg)
                  2'd0:    hand_d = {1'b0, hand[2], hand[1]};
                  2'd1:    hand_d = {1'b0, hand[2], hand[0]};
                  default: hand_d = {1'b0, hand[1], hand[0]};
                endcase
              end
            end
            OP_ENACT: begin
              if (op_arg >= hand_n || sel_full) begin
                err_d = 1'b1;
              end else begin
                if (sel_card) board_lib_d = board_lib + 3'd1;
                else          board_fas_d = board_fas + 3'd1;
                disc_n_d   = disc_n + 5'(hand_n) - 5'd1;
                disc_lib_d = disc_lib_q + 5'(hand_lib) - 5'(sel_card);
                hand_d     = 3'b000;
                hand_n_d   = 2'd0;
              end
            end
            OP_TOPDECK: begin
              if (stack_n == 5'd0 || top_full) begin
                err_d = 1'b1;
              end else begin
                if (top_card) board_lib_d = board_lib + 3'd1;
                else          board_fas_d = board_fas + 3'd1;
                stack_d[top_pos] = 1'b0;
                stack_n_d        = stack_n - 5'd1;
              end
            end
            default: err_d = 1'b1;
          endcase
`ifdef SNPU_AUTO_RESHUFFLE_EN
          if (!err_d && stack_n_d < 5'd3 &&
              (op_code == OP_DRAW3 || op_code == OP_ENACT || op_code == OP_TOPDECK)) begin
            state_d = S_MERGE;
          end
`endif
        end
      end
      // Discard lands on top of the stack: liberals first, then fascists.
      S_MERGE: begin
        stack_d    = stack_q | (low_mask(disc_lib_q) << stack_n);
        stack_n_d  = merged_n;
        disc_n_d   = 5'd0;
        disc_lib_d = 5'd0;
        idx_d      = merged_n - 5'd1;
        state_d    = (merged_n <= 5'd1) ? S_IDLE : S_SWAP;
      end
      // One Fisher-Yates step per cycle; out-of-range candidates retry next cycle.
      S_SWAP: begin
        if (swap_j <= idx_q) begin
          stack_d[idx_q]  = stack_q[swap_j];
          stack_d[swap_j] = stack_q[idx_q];
          idx_d           = idx_q - 5'd1;
          if (idx_q == 5'd1) state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
    peek_d = 3'b000;
    if (stack_n_d >= 5'd1) peek_d[0] = stack_d[stack_n_d - 5'd1];
    if (stack_n_d >= 5'd2) peek_d[1] = stack_d[stack_n_d - 5'd2];
    if (stack_n_d >= 5'd3) peek_d[2] = stack_d[stack_n_d - 5'd3];
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      stack_q    <= STACK_INIT;
      lfsr_q     <= LFSR_SEED;
      idx_q      <= 5'd0;
      disc_lib_q <= 5'd0;
      stack_n    <= DECK_CNT;
      disc_n     <= 5'd0;
      hand       <= 3'b000;
      hand_n     <= 2'd0;
      board_lib  <= 3'd0;
      board_fas  <= 3'd0;
      err        <= 1'b0;
      busy       <= 1'b0;
      op_ready   <= 1'b1;
      peek       <= 3'b000;
    end else begin
      state_q    <= state_d;
      stack_q    <= stack_d;
      lfsr_q     <= lfsr_d;
      idx_q      <= idx_d;
      disc_lib_q <= disc_lib_d;
      stack_n    <= stack_n_d;
      disc_n     <= disc_n_d;
      hand       <= hand_d;
      hand_n     <= hand_n_d;
      board_lib  <= board_lib_d;
      board_fas  <= board_fas_d;
      err        <= err_d;
      busy       <= busy_d;
      op_ready   <= ~busy_d;
      peek       <= peek_d;
    end
  end

endmodule

// File: tb/tb_snpu_policy_deck.sv
`timescale 1ns/1ps
// Self-checking bench for snpu_policy_deck: directed steps plus randomized ops against a queue-based deck model.
module tb_snpu_policy_deck;

  localparam logic [7:0] SEED = 8'hA5;
`ifdef SNPU_AUTO_RESHUFFLE_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       op_valid;
  logic [2:0] op_code;
  logic [1:0] op_arg;
  logic       op_ready, busy, err;
  logic [2:0] hand, peek, board_lib, board_fas;
  logic [1:0] hand_n;
  logic [4:0] stack_n, disc_n;

  always #5 clk = ~clk;

  snpu_policy_deck #(.LFSR_SEED(SEED)) dut (
    .clk(clk), .rst_n(rst_n), .op_valid(op_valid), .op_code(op_code), .op_arg(op_arg),
    .op_ready(op_ready), .busy(busy), .err(err), .hand(hand), .hand_n(hand_n),
    .peek(peek), .stack_n(stack_n), .disc_n(disc_n),
    .board_lib(board_lib), .board_fas(board_fas)
  );

  int n_chk = 0;
  int n_pass = 0;
  int last_busy = 0;

  // Deck model: stack queue is bottom-first, hand queue is hand index order.
  bit m_stk[$];
  bit m_hand[$];
  int m_dn, m_dl, m_bl, m_bf;
  bit m_err;

  function automatic logic [7:0] lfsr_next(input logic [7:0] s);
    return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
  endfunction

  // Free-running LFSR value for the current cycle, reloaded by reset or a RESET op.
  logic [7:0] sh;
  always @(posedge clk) sh <= (!rst_n || (op_valid && op_code == 3'd1)) ? SEED : lfsr_next(sh);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
  endtask

  task automatic model_reset();
    m_stk.delete();
    for (int i = 0; i < 17; i++) m_stk.push_back(i < 6);
    m_hand.delete();
    m_dn = 0; m_dl = 0; m_bl = 0; m_bf = 0; m_err = 0;
  endtask

  task automatic model_apply(input logic [2:0] c, input logic [1:0] a, output bit shuf);
    bit card;
    shuf = 0;
    m_err = 0;
    case (c)
      3'd0: ;
      3'd1: model_reset();
      3'd2: shuf = 1;
      3'd3: begin
        if (m_hand.size() != 0 || m_stk.size() < 3) m_err = 1;
        else begin
          repeat (3) m_hand.push_back(m_stk.pop_back());
          shuf = AUTO && m_stk.size() < 3;
        end
      end
      3'd4: begin
        if (int'(a) >= m_hand.size()) m_err = 1;
        else begin
          card = m_hand[a];
          m_hand.delete(int'(a));
          m_dn++; m_dl += int'(card);
        end
      end
      3'd5: begin
        if (int'(a) >= m_hand.size()) m_err = 1;
        else begin
          card = m_hand[a];
          if (card ? (m_bl == 5) : (m_bf == 6)) m_err = 1;
          else begin
            if (card) m_bl++; else m_bf++;
            for (int i = 0; i < m_hand.size(); i++)
              if (i != int'(a)) begin m_dn++; m_dl += int'(m_hand[i]); end
            m_hand.delete();
            shuf = AUTO && m_stk.size() < 3;
          end
        end
      end
      3'd6: begin
        if (m_stk.size() == 0) m_err = 1;
        else begin
          card = m_stk[m_stk.size()-1];
          if (card ? (m_bl == 5) : (m_bf == 6)) m_err = 1;
          else begin
            void'(m_stk.pop_back());
            if (card) m_bl++; else m_bf++;
            shuf = AUTO && m_stk.size() < 3;
          end
        end
      end
      default: m_err = 1;
    endcase
  endtask

  // Merge, then Fisher-Yates driven by the LFSR sequence starting two cycles after acceptance.
  task automatic model_shuffle(input logic [7:0] l0, output int cycles);
    logic [7:0] l;
    int i, m, j, guard;
    bit t;
    repeat (m_dl) m_stk.push_back(1'b1);
    repeat (m_dn - m_dl) m_stk.push_back(1'b0);
    m_dn = 0; m_dl = 0;
    cycles = 1;
    l = lfsr_next(lfsr_next(l0));
    i = m_stk.size() - 1;
    guard = 0;
    while (i > 0 && guard < 3000) begin
      m = 1;
      while (m < i) m = 2 * m + 1;
      j = int'(l[4:0]) & m;
      cycles++;
      if (j <= i) begin
        t = m_stk[i]; m_stk[i] = m_stk[j]; m_stk[j] = t;
        i--;
      end
      l = lfsr_next(l);
      guard++;
    end
  endtask

  task automatic check_all(input string tag);
    logic [2:0] eh, ep;
    eh = 3'b000; ep = 3'b000;
    for (int i = 0; i < m_hand.size(); i++) eh[i] = m_hand[i];
    for (int i = 0; i < 3; i++) if (i < m_stk.size()) ep[i] = m_stk[m_stk.size()-1-i];
    chk({tag, ".stack_n"}, stack_n, m_stk.size());
    chk({tag, ".peek"}, peek, ep);
    chk({tag, ".hand"}, hand, eh);
    chk({tag, ".hand_n"}, hand_n, m_hand.size());
    chk({tag, ".disc_n"}, disc_n, m_dn);
    chk({tag, ".board_lib"}, board_lib, m_bl);
    chk({tag, ".board_fas"}, board_fas, m_bf);
    chk({tag, ".err"}, err, m_err);
    chk({tag, ".busy"}, busy, 1'b0);
    chk({tag, ".op_ready"}, op_ready, 1'b1);
  endtask

  // Drives one op for one cycle; optionally holds a DRAW3 on the bus while busy.
  task automatic issue(input logic [2:0] c, input logic [1:0] a, input bit hold);
    logic [7:0] l0;
    bit shuf;
    int exp_cyc, cnt;
    l0 = sh;
    op_valid = 1'b1; op_code = c; op_arg = a;
    model_apply(c, a, shuf);
    @(posedge clk); #1;
    if (hold) op_code = 3'd3;
    else      op_valid = 1'b0;
    last_busy = 0;
    if (shuf) begin
      model_shuffle(l0, exp_cyc);
      cnt = 0;
      while (busy === 1'b1 && cnt < 4000) begin
        cnt++;
        @(posedge clk); #1;
      end
      chk("shuffle.busy_cycles", cnt, exp_cyc);
      last_busy = cnt;
    end
    op_valid = 1'b0; op_code = 3'd0;
    check_all($sformatf("op%0d_arg%0d", c, a));
  endtask

  initial begin
    int r;
    logic [2:0] c;
    rst_n = 1'b0; op_valid = 1'b0; op_code = 3'd0; op_arg = 2'd0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();
    check_all("reset");

    // Legislative round from a fresh deck.
    issue(3'd1, 2'd0, 1'b0);
    issue(3'd3, 2'd0, 1'b0);
    chk("draw.hand", hand, 3'b000);
    chk("draw.stack_n", stack_n, 5'd14);
    issue(3'd4, 2'd1, 1'b0);
    chk("discard.disc_n", disc_n, 5'd1);
    issue(3'd5, 2'd0, 1'b0);
    chk("enact.board_fas", board_fas, 3'd1);
    chk("enact.disc_n", disc_n, 5'd2);

    // Shuffle with a DRAW3 held on the bus that must be ignored while busy.
    issue(3'd2, 2'd0, 1'b1);
    chk("shuffle.min_busy", last_busy >= 16, 1'b1);
    chk("shuffle.stack_n", stack_n, 5'd16);

    // Illegal ops leave state unchanged; NOP clears err.
    issue(3'd3, 2'd0, 1'b0);
    issue(3'd4, 2'd0, 1'b0);
    issue(3'd4, 2'd2, 1'b0);
    chk("illegal.discard2", err, 1'b1);
    issue(3'd3, 2'd0, 1'b0);
    chk("illegal.draw_full", err, 1'b1);
    issue(3'd7, 2'd0, 1'b0);
    chk("illegal.op7", err, 1'b1);
    issue(3'd0, 2'd0, 1'b0);
    chk("nop.err", err, 1'b0);

    // Reset asserted on the fifth SWAP cycle abandons the shuffle.
    op_valid = 1'b1; op_code = 3'd2; op_arg = 2'd0;
    @(posedge clk); #1;
    op_valid = 1'b0; op_code = 3'd0;
    chk("midshuf.busy_merge", busy, 1'b1);
    repeat (5) begin @(posedge clk); #1; end
    chk("midshuf.busy_swap5", busy, 1'b1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
    check_all("midshuf_reset");

    // Run the stack down to two cards.
    for (int k = 0; k < 4; k++) begin
      issue(3'd3, 2'd0, 1'b0);
      repeat (3) issue(3'd4, 2'd0, 1'b0);
    end
    issue(3'd3, 2'd0, 1'b0);
`ifdef SNPU_AUTO_RESHUFFLE_EN
    chk("auto.busy_seen", last_busy >= 1, 1'b1);
    chk("auto.stack_n", stack_n, 5'd14);
`else
    repeat (3) issue(3'd4, 2'd0, 1'b0);
    issue(3'd3, 2'd0, 1'b0);
    chk("low.draw_err", err, 1'b1);
    chk("low.stack_n", stack_n, 5'd2);
`endif

    // Randomized op stream with idle gaps.
    for (int n = 0; n < 300; n++) begin
      r = $urandom_range(0, 99);
      if      (r < 3)  c = 3'd1;
      else if (r < 15) c = 3'd2;
      else if (r < 40) c = 3'd3;
      else if (r < 60) c = 3'd4;
      else if (r < 78) c = 3'd5;
      else if (r < 90) c = 3'd6;
      else if (r < 95) c = 3'd0;
      else             c = 3'd7;
      issue(c, 2'($urandom_range(0, 3)), 1'b0);
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
